// File: rtl/obstacle_engine.sv
// obstacle_engine: two-slot obstacle scroller with LFSR-spaced spawning, scoring and registered collision
module obstacle_engine #(
  parameter int          SCREEN_W  = 640,
  parameter int          OBS_W     = 20,
  parameter int          OBS_H     = 40,
  parameter int          DINO_X    = 80,
  parameter int          DINO_W    = 30,
  parameter int          SPEED     = 4,
  parameter int          MIN_GAP   = 160,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic [9:0] dino_y,
  input  logic       game_over,
  output logic [9:0] obs0_x,
  output logic       obs0_valid,
  output logic [9:0] obs1_x,
  output logic       obs1_valid,
  output logic       collision,
  output logic [15:0] score
);
  localparam logic [9:0]  SW   = 10'(SCREEN_W);
  localparam logic [9:0]  SP   = 10'(SPEED);
  localparam logic [9:0]  MG   = 10'(MIN_GAP);
  localparam logic [9:0]  OH   = 10'(OBS_H);
  localparam logic [10:0] XR   = 11'(DINO_X + DINO_W);
  localparam logic [10:0] XL   = 11'(DINO_X);
  localparam logic [10:0] OW   = 11'(OBS_W);
  localparam logic [15:0] SEED = LFSR_SEED == 16'h0 ? 16'h0001 : LFSR_SEED;
  localparam logic [9:0]  THR0 = MG + {3'b0, LFSR_SEED[6:0]};
  logic [1:0][9:0] x_q, x_d;
  logic [1:0]      v_q, v_d;
  logic [15:0]     score_q, score_d, lfsr_q, lfsr_d;
  logic [9:0]      gap_cnt_q, gap_cnt_d, gap_thresh_q, gap_thresh_d, gap_next;
  logic            collision_q, collision_d, adv, slot;
  logic [1:0]      ret;
  logic [16:0]     score_sum;
  logic [10:0]     gap_sum;
  assign adv       = game_tick & ~game_over;
  assign ret       = 2'(v_q[0] && x_q[0] < SP) + 2'(v_q[1] && x_q[1] < SP);
  assign score_sum = 17'(score_q) + 17'(ret);
  assign gap_sum   = {1'b0, gap_cnt_q} + {1'b0, SP};
  assign gap_next  = gap_sum[10] ? 10'h3FF : gap_sum[9:0];
  assign obs0_x     = x_q[0];
  assign obs1_x     = x_q[1];
  assign obs0_valid = v_q[0];
  assign obs1_valid = v_q[1];
  assign collision  = collision_q;
  assign score      = score_q;
  // frame advance: scroll/retire, then spawn into the lowest free slot, then step the LFSR
  always_comb begin
    x_d          = x_q;
    v_d          = v_q;
    score_d      = score_q;
    gap_cnt_d    = gap_cnt_q;
    gap_thresh_d = gap_thresh_q;
    lfsr_d       = lfsr_q;
    slot         = 1'b0;
    if (adv) begin
      for (int i = 0; i < 2; i++) begin
        v_d[i] = v_q[i] && x_q[i] >= SP;
        x_d[i] = v_d[i] ? x_q[i] - SP : x_q[i];
      end
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      slot    = v_d[0];
      if (gap_next >= gap_thresh_q && !(v_d[0] && v_d[1])) begin
        x_d[slot]    = SW;
        v_d[slot]    = 1'b1;
        gap_cnt_d    = '0;
        gap_thresh_d = MG + {3'b0, lfsr_d[6:0]};
      end else gap_cnt_d = gap_next;
    end
  end
  // overlap test in 11 bits so x+OBS_W cannot wrap
  always_comb begin
    collision_d = 1'b0;
    for (int i = 0; i < 2; i++)
      collision_d = collision_d | (v_q[i] && {1'b0, x_q[i]} < XR && {1'b0, x_q[i]} + OW > XL && dino_y < OH);
  end
  // state registers; collision refreshes every cycle, everything else only changes on advance
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q          <= '0;
      v_q          <= '0;
      score_q      <= '0;
      collision_q  <= 1'b0;
      gap_cnt_q    <= '0;
      gap_thresh_q <= THR0;
      lfsr_q       <= SEED;
    end else begin
      x_q          <= x_d;
      v_q          <= v_d;
      score_q      <= score_d;
      collision_q  <= collision_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_thresh_q <= gap_thresh_d;
      lfsr_q       <= lfsr_d;
    end
  end
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: directed test-plan points plus randomized run against a behavioural model
module tb_obstacle_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_tick = 1'b0;
  logic [9:0]  dino_y = '0;
  logic        game_over = 1'b0;
  logic [9:0]  obs0_x, obs1_x;
  logic        obs0_valid, obs1_valid, collision;
  logic [15:0] score;
  int n_chk = 0, n_err = 0;
  int mx[2], mv[2], msc, mgap, mthr, ml, mcol;
  obstacle_engine dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .dino_y(dino_y), .game_over(game_over),
    .obs0_x(obs0_x), .obs0_valid(obs0_valid), .obs1_x(obs1_x), .obs1_valid(obs1_valid),
    .collision(collision), .score(score)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mx = '{0, 0};
    mv = '{0, 0};
    msc = 0; mgap = 0; mcol = 0;
    ml = 'hACE1;
    mthr = 160 + ('hACE1 & 127);
  endtask
  task automatic model_step(input int t, input int g, input int dy, input int r);
    int c, s;
    if (r == 0) begin
      model_reset();
      return;
    end
    c = 0;
    for (int i = 0; i < 2; i++)
      if (mv[i] != 0 && mx[i] < 80 + 30 && mx[i] + 20 > 80 && dy < 40) c = 1;
    mcol = c;
    if (t == 0 || g != 0) return;
    for (int i = 0; i < 2; i++)
      if (mv[i] != 0) begin
        if (mx[i] < 4) begin mv[i] = 0; msc++; end
        else mx[i] -= 4;
      end
    if (msc > 65535) msc = 65535;
    mgap = mgap + 4 > 1023 ? 1023 : mgap + 4;
    ml = ((ml << 1) & 'hFFFF) | (((ml >> 15) ^ (ml >> 13) ^ (ml >> 12) ^ (ml >> 10)) & 1);
    if (mgap >= mthr && (mv[0] == 0 || mv[1] == 0)) begin
      s = mv[0] != 0 ? 1 : 0;
      mv[s] = 1; mx[s] = 640; mgap = 0;
      mthr = 160 + (ml & 127);
    end
  endtask
  task automatic step(input int t, input int g, input int dy, input int r);
    game_tick = t[0];
    game_over = g[0];
    dino_y    = dy[9:0];
    rst       = r[0];
    model_step(t, g, dy, r);
    @(posedge clk);
    #1;
    check("x0", obs0_x, mx[0]);
    check("v0", obs0_valid, mv[0]);
    check("x1", obs1_x, mx[1]);
    check("v1", obs1_valid, mv[1]);
    check("col", collision, mcol);
    check("score", score, msc);
  endtask
  initial begin
    int dy, sc, v1, x1;
    model_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_v0", obs0_valid, 0);
    check("rst_x0", obs0_x, 0);
    check("rst_score", score, 0);
    check("rst_col", collision, 0);
    repeat (10) step(1, 1, 0, 1);
    check("frozen_v0", obs0_valid, 0);
    check("frozen_score", score, 0);
    for (int t = 1; t <= 65; t++) begin
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      if (t == 64) check("pre_spawn_v0", obs0_valid, 0);
      if (t == 65) begin
        check("spawn_v0", obs0_valid, 1);
        check("spawn_x0", obs0_x, 640);
      end
    end
    dy = 0;
    for (int k = 1; k <= 161; k++) begin
      step(1, 0, dy, 1);
      if (k == 85) begin
        sc = score; v1 = obs1_valid; x1 = obs1_x;
        repeat (20) step(1, 1, dy, 1);
        check("freeze_x0", obs0_x, 300);
        check("freeze_score", score, sc);
        check("freeze_v1", obs1_valid, v1);
        check("freeze_x1", obs1_x, x1);
      end
      if (k == 86) check("thaw_x0", obs0_x, 296);
      if (k == 132) check("near_col", collision, 0);
      if (k == 133) begin
        check("x0_108", obs0_x, 108);
        step(0, 0, dy, 1);
        check("hit", collision, 1);
        dy = 60;
        step(0, 0, dy, 1);
        check("jump_clear", collision, 0);
      end
      if (k == 160) check("x0_zero", obs0_x, 0);
      if (k == 161) check("retire_score", score, 1);
    end
    for (int n = 0; n < 4000; n++)
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 80)), int'($urandom_range(0, 499) != 0));
    step(0, 0, 0, 0);
    check("mid_rst_v0", obs0_valid, 0);
    check("mid_rst_v1", obs1_valid, 0);
    check("mid_rst_score", score, 0);
    for (int t = 1; t <= 65; t++) begin
      step(1, 0, 0, 1);
      if (t == 64) check("re_pre_spawn", obs0_valid, 0);
      if (t == 65) check("re_spawn_x0", obs0_x, 640);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
